// File: rtl/logic_unit_pkg.sv
// Shared opcode definitions and legality helper for the bitwise logic unit.
// LOGIC_UNIT_ZBB_EN enables the ANDN/ORN/XNOR opcodes.
package logic_unit_pkg;

    localparam int LU_OP_W = 3;

    typedef enum logic [LU_OP_W-1:0] {
        LU_AND  = 3'd0,
        LU_OR   = 3'd1,
        LU_XOR  = 3'd2,
        LU_ANDN = 3'd3,
        LU_ORN  = 3'd4,
        LU_XNOR = 3'd5,
        LU_RSV6 = 3'd6,
        LU_RSV7 = 3'd7
    } lu_op_e;

    function automatic logic lu_is_legal(lu_op_e op);
`ifdef LOGIC_UNIT_ZBB_EN
        return (op <= LU_XNOR);
`else
        return (op <= LU_XOR);
`endif
    endfunction

endpackage

// File: rtl/logic_unit_if.sv
// Operand/result handshake bundle for logic_unit; slave is the unit's view.
interface logic_unit_if #(parameter int WIDTH = 32);
    import logic_unit_pkg::*;

    logic             in_valid;
    logic             in_ready;
    lu_op_e           in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_err;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_err
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_err
    );

endinterface

// File: rtl/logic_unit_fifo2.sv
// Two-entry result buffer kept as head/tail registers; head always drives the output.
module fifo2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic [1:0]    count;
    logic [DW-1:0] head_q;
    logic [DW-1:0] tail_q;
    logic          push;
    logic          pop;

    // in_ready depends only on stored count, never on out_ready.
    assign in_ready  = rstn && (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = head_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (pop && (count == 2'd2))
                head_q <= tail_q;
            if (push) begin
                if ((count == 2'd0) || ((count == 2'd1) && pop))
                    head_q <= in_data;
                else
                    tail_q <= in_data;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/logic_unit.sv
// Pipelined WIDTH-bit bitwise logic unit: opcode decode/compute feeding a 2-entry buffer.
// LOGIC_UNIT_ZBB_EN adds ANDN/ORN/XNOR; otherwise those opcodes report out_err.
module logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rstn,
    logic_unit_if.slave  lu
);

    logic [WIDTH-1:0] res;
    logic             zero;
    logic             err;
    logic [WIDTH+1:0] head;

    always_comb begin
        res = '0;
        case (lu.in_op)
            LU_AND:  res = lu.in_a & lu.in_b;
            LU_OR:   res = lu.in_a | lu.in_b;
            LU_XOR:  res = lu.in_a ^ lu.in_b;
`ifdef LOGIC_UNIT_ZBB_EN
            LU_ANDN: res = lu.in_a & ~lu.in_b;
            LU_ORN:  res = lu.in_a | ~lu.in_b;
            LU_XNOR: res = ~(lu.in_a ^ lu.in_b);
`endif
            default: res = '0;
        endcase
    end

    assign err  = !lu_is_legal(lu.in_op);
    assign zero = (res == '0);

    fifo2 #(.DW(WIDTH + 2)) u_fifo2 (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (lu.in_valid),
        .in_ready  (lu.in_ready),
        .in_data   ({err, zero, res}),
        .out_valid (lu.out_valid),
        .out_ready (lu.out_ready),
        .out_data  (head)
    );

    assign lu.out_result = head[WIDTH-1:0];
    assign lu.out_zero   = head[WIDTH];
    assign lu.out_err    = head[WIDTH+1];

endmodule

// File: tb/tb_logic_unit.sv
// Directed bench for logic_unit (WIDTH=8) with a queue-based reference model.
module tb_logic_unit;
    import logic_unit_pkg::*;

    localparam int W = 8;

    logic clk;
    logic rstn;
    int   n_chk;
    int   n_pass;
    logic [W+1:0] exp_q[$];

    logic_unit_if #(.WIDTH(W)) lu ();

    logic_unit #(.WIDTH(W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .lu   (lu)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, got no finish, want finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: {err, zero, result} from the opcode table.
    function automatic logic [W+1:0] model(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         e;
        r = '0;
        e = 1'b0;
        case (op)
            0: r = a & b;
            1: r = a | b;
            2: r = a ^ b;
`ifdef LOGIC_UNIT_ZBB_EN
            3: r = a & ~b;
            4: r = a | ~b;
            5: r = ~(a ^ b);
`endif
            default: e = 1'b1;
        endcase
        return {e, (r == '0), r};
    endfunction

    // Cycle-level compare against the model; inputs are stable around each negedge.
    always @(negedge clk) begin
        logic fin, fout;
        if (!rstn) begin
            exp_q.delete();
            chk("rst_out_valid", 32'(lu.out_valid), 32'd0);
            chk("rst_in_ready", 32'(lu.in_ready), 32'd0);
            chk("rst_out_word", 32'({lu.out_err, lu.out_zero, lu.out_result}), 32'd0);
        end else begin
            chk("mdl_in_ready", 32'(lu.in_ready), 32'(exp_q.size() < 2));
            chk("mdl_out_valid", 32'(lu.out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0)
                chk("mdl_out_word", 32'({lu.out_err, lu.out_zero, lu.out_result}), 32'(exp_q[0]));
            fin  = lu.in_valid && (exp_q.size() < 2);
            fout = lu.out_ready && (exp_q.size() != 0);
            if (fout) void'(exp_q.pop_front());
            if (fin) exp_q.push_back(model(int'(lu.in_op), lu.in_a, lu.in_b));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic ordy);
        lu.in_valid  = v;
        lu.in_op     = lu_op_e'(op);
        lu.in_a      = a;
        lu.in_b      = b;
        lu.out_ready = ordy;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rstn   = 1'b1;
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        #1 rstn = 1'b0;
        step();
        step();
        chk("reset_valid", 32'(lu.out_valid), 32'd0);
        chk("reset_ready", 32'(lu.in_ready), 32'd0);
        rstn = 1'b1;
        #1;
        chk("post_reset_ready", 32'(lu.in_ready), 32'd1);

        // AND F0 & 3C, 1-cycle latency
        drive(1'b1, 3'd0, 8'hF0, 8'h3C, 1'b1);
        step();
        chk("and_valid", 32'(lu.out_valid), 32'd1);
        chk("and_result", 32'(lu.out_result), 32'h30);
        chk("and_flags", 32'({lu.out_err, lu.out_zero}), 32'd0);

        // back-to-back OR, XOR, AND
        drive(1'b1, 3'd1, 8'h0F, 8'hF0, 1'b1);
        step();
        chk("or_result", 32'({lu.out_err, lu.out_zero, lu.out_result}), 32'h0FF);
        drive(1'b1, 3'd2, 8'hAA, 8'hAA, 1'b1);
        step();
        chk("xor_result", 32'({lu.out_err, lu.out_zero, lu.out_result}), 32'h100);
        drive(1'b1, 3'd0, 8'h01, 8'h02, 1'b1);
        step();
        chk("and0_result", 32'({lu.out_err, lu.out_zero, lu.out_result}), 32'h100);
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
        step();
        chk("drained_valid", 32'(lu.out_valid), 32'd0);

        // backpressure: third beat must wait
        drive(1'b1, 3'd0, 8'h11, 8'h33, 1'b0);
        step();
        chk("bp1_result", 32'(lu.out_result), 32'h11);
        chk("bp1_ready", 32'(lu.in_ready), 32'd1);
        drive(1'b1, 3'd1, 8'h40, 8'h02, 1'b0);
        step();
        chk("bp2_ready", 32'(lu.in_ready), 32'd0);
        chk("bp2_frozen", 32'(lu.out_result), 32'h11);
        drive(1'b1, 3'd2, 8'h0F, 8'h01, 1'b0);
        step();
        step();
        chk("bp3_frozen", 32'(lu.out_result), 32'h11);
        chk("bp3_ready", 32'(lu.in_ready), 32'd0);
        lu.out_ready = 1'b1;
        step();
        chk("drain1_result", 32'(lu.out_result), 32'h42);
        chk("drain1_ready", 32'(lu.in_ready), 32'd1);
        step();
        chk("drain2_result", 32'(lu.out_result), 32'h0E);
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
        step();
        chk("drain3_valid", 32'(lu.out_valid), 32'd0);

        // ORN build-dependent
        drive(1'b1, 3'd4, 8'h00, 8'h0F, 1'b1);
        step();
`ifdef LOGIC_UNIT_ZBB_EN
        chk("orn_word", 32'({lu.out_err, lu.out_zero, lu.out_result}), 32'h0F0);
`else
        chk("orn_word", 32'({lu.out_err, lu.out_zero, lu.out_result}), 32'h300);
`endif

        // reserved opcodes consumed without stall
        drive(1'b1, 3'd7, 8'hFF, 8'hFF, 1'b1);
        step();
        chk("op7_word", 32'({lu.out_err, lu.out_zero, lu.out_result}), 32'h300);
        chk("op7_ready", 32'(lu.in_ready), 32'd1);
        drive(1'b1, 3'd6, 8'h5A, 8'hA5, 1'b1);
        step();
        chk("op6_word", 32'({lu.out_err, lu.out_zero, lu.out_result}), 32'h300);
        drive(1'b1, 3'd2, 8'h5A, 8'hFF, 1'b1);
        step();
        chk("after_rsv_word", 32'({lu.out_err, lu.out_zero, lu.out_result}), 32'h0A5);

        // reset with two buffered beats
        drive(1'b1, 3'd0, 8'hFF, 8'h0F, 1'b0);
        step();
        drive(1'b1, 3'd1, 8'h01, 8'h02, 1'b0);
        step();
        chk("full_ready", 32'(lu.in_ready), 32'd0);
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        rstn = 1'b0;
        #1;
        chk("midrst_valid", 32'(lu.out_valid), 32'd0);
        chk("midrst_ready", 32'(lu.in_ready), 32'd0);
        chk("midrst_result", 32'(lu.out_result), 32'd0);
        step();
        step();
        rstn = 1'b1;
        #1;
        chk("rel_ready", 32'(lu.in_ready), 32'd1);
        chk("rel_valid", 32'(lu.out_valid), 32'd0);
        drive(1'b1, 3'd0, 8'hFF, 8'h5A, 1'b1);
        step();
        chk("new_beat", 32'({lu.out_valid, lu.out_result}), 32'h15A);
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
        step();
        chk("no_stale", 32'(lu.out_valid), 32'd0);

        // mixed burst against the model
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 1)));
            step();
        end
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
        step();
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
